// File: rtl/st7920_serial_receiver.sv
// ST7920 3-wire serial receiver: reassembles 24-bit frames, decodes commands,
// and turns extended-mode GDRAM data writes into framebuffer byte writes.
module st7920_serial_receiver (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       lcd_clk,
  input  logic       lcd_data,
  input  logic       lcd_cs,
  output logic       cmd_valid,
  output logic       cmd_rs,
  output logic       cmd_rw,
  output logic [7:0] cmd_data,
  output logic       frame_err,
  output logic       fb_we,
  output logic [9:0] fb_addr,
  output logic [7:0] fb_wdata,
  output logic       re,
  output logic       gfx_on,
  output logic       disp_on
);

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t     state;
  logic [2:0] clk_sync;
  logic [1:0] data_sync;
  logic [1:0] cs_sync;
  logic [2:0] ones;
  logic [1:0] hdr_cnt;
  logic [3:0] data_cnt;
  logic [3:0] hi;
  logic [3:0] lo;
  logic       pad_err;
  logic       rw_bit;
  logic       rs_bit;
  logic [6:0] vy;
  logic [4:0] bp;
  logic       phase;

  logic fall;
  logic bit_in;
  logic cs_on;

  // clk_sync[2] is the previous synchronized level, used for edge detection
  assign fall   = clk_sync[2] & ~clk_sync[1];
  assign bit_in = data_sync[1];
  assign cs_on  = cs_sync[1];

  // Synchronizers, frame state machine, output registers and command decode
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      clk_sync  <= 3'b000;
      data_sync <= 2'b00;
      cs_sync   <= 2'b00;
      state     <= HUNT;
      ones      <= 3'd0;
      hdr_cnt   <= 2'd0;
      data_cnt  <= 4'd0;
      hi        <= 4'd0;
      lo        <= 4'd0;
      pad_err   <= 1'b0;
      rw_bit    <= 1'b0;
      rs_bit    <= 1'b0;
      vy        <= 7'd0;
      bp        <= 5'd0;
      phase     <= 1'b0;
      cmd_valid <= 1'b0;
      cmd_rs    <= 1'b0;
      cmd_rw    <= 1'b0;
      cmd_data  <= 8'd0;
      frame_err <= 1'b0;
      fb_we     <= 1'b0;
      fb_addr   <= 10'd0;
      fb_wdata  <= 8'd0;
      re        <= 1'b0;
      gfx_on    <= 1'b0;
      disp_on   <= 1'b0;
    end else begin
      clk_sync  <= {clk_sync[1], clk_sync[0], lcd_clk};
      data_sync <= {data_sync[0], lcd_data};
      cs_sync   <= {cs_sync[0], lcd_cs};
      cmd_valid <= 1'b0;
      frame_err <= 1'b0;
      fb_we     <= 1'b0;

      // Decode state follows the frame by one cycle so fb_we uses the old vy/bp
      if (cmd_valid && !cmd_rw) begin
        if (cmd_rs) begin
          bp <= bp + 5'd1;
        end else if (cmd_data[7:5] == 3'b001) begin
          re    <= cmd_data[2];
          phase <= 1'b0;
          if (cmd_data[2]) begin
            gfx_on <= cmd_data[1];
          end else begin
            gfx_on <= gfx_on;
          end
        end else if (cmd_data[7:3] == 5'b00001) begin
          disp_on <= cmd_data[2];
          phase   <= 1'b0;
        end else if (cmd_data[7] && re) begin
          if (!phase) begin
            vy <= cmd_data[6:0];
          end else begin
            bp <= {cmd_data[3:0], 1'b0};
          end
          phase <= ~phase;
        end else begin
          phase <= 1'b0;
        end
      end else begin
        phase <= phase;
      end

      if (!cs_on) begin
        state <= HUNT;
        ones  <= 3'd0;
      end else if (fall) begin
        case (state)
          HUNT: begin
            if (!bit_in) begin
              ones <= 3'd0;
            end else if (ones == 3'd4) begin
              ones    <= 3'd0;
              hdr_cnt <= 2'd0;
              state   <= HDR;
            end else begin
              ones <= ones + 3'd1;
            end
          end
          HDR: begin
            hdr_cnt <= hdr_cnt + 2'd1;
            case (hdr_cnt)
              2'd0: rw_bit <= bit_in;
              2'd1: rs_bit <= bit_in;
              default: begin
                if (bit_in) begin
                  frame_err <= 1'b1;
                  state     <= HUNT;
                end else begin
                  data_cnt <= 4'd0;
                  pad_err  <= 1'b0;
                  state    <= DATA;
                end
              end
            endcase
          end
          DATA: begin
            data_cnt <= data_cnt + 4'd1;
            case (data_cnt[3:2])
              2'd0:    hi <= {hi[2:0], bit_in};
              2'd2:    lo <= {lo[2:0], bit_in};
              default: pad_err <= pad_err | bit_in;
            endcase
            if (data_cnt == 4'd15) begin
              state <= HUNT;
              ones  <= 3'd0;
              if (pad_err || bit_in) begin
                frame_err <= 1'b1;
              end else begin
                cmd_valid <= 1'b1;
                cmd_rs    <= rs_bit;
                cmd_rw    <= rw_bit;
                cmd_data  <= {hi, lo};
                // Lower display half (bp>=16) lands at +512: address is {bp[4], vy[4:0], bp[3:0]}
                if (rs_bit && !rw_bit && re && (vy[6:5] == 2'b00)) begin
                  fb_we    <= 1'b1;
                  fb_addr  <= {bp[4], vy[4:0], bp[3:0]};
                  fb_wdata <= {hi, lo};
                end else begin
                  fb_we <= 1'b0;
                end
              end
            end else begin
              state <= DATA;
            end
          end
          default: begin
            state <= HUNT;
            ones  <= 3'd0;
          end
        endcase
      end else begin
        state <= state;
      end
    end
  end

endmodule
